multi_clock_gen: RTL and testbench
==================================

MULTI_CLOCK_GEN -- requirements
Module: multi_clock_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of independent output clock channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the per-channel period, high-time and phase fields, in cycles of clk.
REQ-003 The block SHALL have port clk  input  1  reference clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port enable  input  NUM_CH  per-channel run request, level-sensitive.
REQ-006 The block SHALL have port cfg_load  input  NUM_CH  per-channel one-cycle strobe that captures the channel's config fields.
REQ-007 The block SHALL have port cfg_period  input  NUM_CH*CNT_W  per-channel period in clk cycles; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-008 The block SHALL have port cfg_high  input  NUM_CH*CNT_W  per-channel high time (duty) in clk cycles.
REQ-009 The block SHALL have port cfg_phase  input  NUM_CH*CNT_W  per-channel start delay in clk cycles.
REQ-010 The block SHALL have port clk_out  output  NUM_CH  generated clocks, each a registered output.
REQ-011 The block SHALL have port running  output  NUM_CH  per-channel flag, high from the first rising edge of clk_out until the channel returns to IDLE.

Function
REQ-012 Each channel SHALL implement the states IDLE, DELAY, HIGH, LOW and STOP_LOW.
- IDLE: clk_out=0, running=0.
- enable sampled high at edge t: if phase=0, enter HIGH with clk_out=1 after edge t+1; otherwise enter DELAY.
- DELAY holds clk_out=0 for exactly phase cycles, then enters HIGH.
REQ-013 HIGH SHALL hold clk_out=1 for eff_high cycles, then enter LOW; LOW SHALL hold clk_out=0 for eff_period-eff_high cycles, then return to HIGH.
REQ-014 Effective values SHALL be clamped:
- eff_period = max(cfg_period, 2).
- eff_high = cfg_high clamped to 1..eff_period-1.
- Result: every running channel toggles, with no stuck level.
REQ-015 If enable falls during DELAY, the channel SHALL abort to IDLE on the next edge with no clk_out pulse.
REQ-016 If enable falls during HIGH or LOW, the channel SHALL finish the current high phase and full low phase, then enter IDLE (glitch-free stop, no shortened pulse).
REQ-017 STOP_LOW SHALL mark a pending stop; if enable rises again before the low phase ends, the channel SHALL resume HIGH with no gap and no added phase delay.
REQ-018 cfg_load SHALL capture the three fields into shadow registers.
- Shadow is applied immediately if the channel is IDLE.
- Otherwise it is applied at the next HIGH entry, so a period never mixes old and new values.
REQ-019 cfg_load coincident with a HIGH entry SHALL apply the new values to that same period.
REQ-020 running SHALL rise in the cycle clk_out first rises and fall in the cycle the channel enters IDLE.
REQ-021 Channels SHALL be fully independent; equal configs enabled in the same cycle SHALL produce edge-aligned clk_out.

Reset
REQ-022 rst_n low SHALL asynchronously force all channels to IDLE, clk_out=0 and running=0, and load the shadows with period=2, high=1, phase=0.
REQ-023 The first enable sample SHALL occur on the first rising clk edge after rst_n is released; a reset mid-period SHALL truncate the output immediately.

Configuration
REQ-024 Macro MULTI_CLOCK_GEN_TICK_EN:
- Defined: adds outputs rise_tick and fall_tick (NUM_CH each). Each is a one-cycle pulse, asserted in the cycle before clk_out rises or falls respectively, for use as a clock-enable by downstream logic.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-025 A shared package clk_gen_pkg SHALL hold:
- the channel state enumeration;
- the default constants (DEF_PERIOD=2, DEF_HIGH=1, DEF_PHASE=0, MIN_PERIOD=2).
REQ-026 The per-channel FSM, counter and shadow registers SHALL be a sub-module clock_gen_ch, instantiated NUM_CH times by a generate loop; the top level only slices vectors.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Ch0 period=10, high=5, phase=0; enable at cycle 0 -> clk_out rises at cycle 1, 5 high / 5 low, repeating; running rises at cycle 1.
- Ch1 period=8, high=2, phase=3 -> first rise 4 cycles after enable is sampled; 2 high / 6 low thereafter.
- Clamping: period=1, high=0 -> behaves as period 2, high 1; period=4, high=9 -> high 3 / low 1.
- enable falls 2 cycles into a 5-cycle high phase -> high completes, 5-cycle low completes, then IDLE; enable re-rises during that low -> next rise exactly at the period boundary.
- cfg_load of period=6 mid-period while running with period=10 -> current period stays 10 and the next period is 6; enable dropped during DELAY -> no pulse.
- rst_n low mid-high -> clk_out=0 and running=0 immediately; with MULTI_CLOCK_GEN_TICK_EN defined, rise_tick pulses one cycle before each clk_out rise.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared definitions for the multi-channel clock generator: the channel
// state enumeration and the reset/clamp constants.
package clk_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW,
    STOP_LOW
  } ch_state_e;

  localparam int DEF_PERIOD = 2;
  localparam int DEF_HIGH   = 1;
  localparam int DEF_PHASE  = 0;
  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/clock_gen_ch.sv
// One generated-clock channel: shadow config, clamped active config, a
// single down-counter and the IDLE/DELAY/HIGH/LOW/STOP_LOW sequencer.
// Optional MULTI_CLOCK_GEN_TICK_EN adds rise_tick/fall_tick, decoded from
// the next-state clock level so they lead clk_out by one cycle.
module clock_gen_ch
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             clk_out,
  output logic             running
`ifdef MULTI_CLOCK_GEN_TICK_EN
  ,
  output logic             rise_tick,
  output logic             fall_tick
`endif
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             running_q, running_d;
  logic [CNT_W-1:0] shd_period_q, shd_high_q, shd_phase_q;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;

  logic [CNT_W-1:0] sel_period, sel_high, sel_phase;
  logic [CNT_W-1:0] sel_eff_period, sel_eff_high;
  logic [CNT_W-1:0] low_cnt;
  logic             enter_high;

  // A load coinciding with a HIGH entry must reach that same period, so the
  // live config bypasses the shadow during the strobe.
  assign sel_period = cfg_load ? cfg_period : shd_period_q;
  assign sel_high   = cfg_load ? cfg_high   : shd_high_q;
  assign sel_phase  = cfg_load ? cfg_phase  : shd_phase_q;

  // Clamp so that a running channel always has at least one high and one low cycle.
  assign sel_eff_period = (sel_period < MIN_P) ? MIN_P : sel_period;
  assign sel_eff_high   = (sel_high == '0)              ? ONE :
                          (sel_high >= sel_eff_period)  ? (sel_eff_period - ONE) :
                                                          sel_high;

  // Active values are already clamped, so the low phase is at least one cycle.
  assign low_cnt = act_period_q - act_high_q - ONE;

  // Shadow capture on each config strobe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_period_q <= CNT_W'(DEF_PERIOD);
      shd_high_q   <= CNT_W'(DEF_HIGH);
      shd_phase_q  <= CNT_W'(DEF_PHASE);
    end else if (cfg_load) begin
      shd_period_q <= cfg_period;
      shd_high_q   <= cfg_high;
      shd_phase_q  <= cfg_phase;
    end
  end

  // Sequencer state, counter, active config and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      running_q    <= 1'b0;
      act_period_q <= CNT_W'(DEF_PERIOD);
      act_high_q   <= CNT_W'(DEF_HIGH);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      running_q    <= running_d;
      act_period_q <= act_period_d;
      act_high_q   <= act_high_d;
    end
  end

  // Next-state decode; a HIGH entry always reloads the active config.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    running_d    = running_q;
    act_period_d = act_period_q;
    act_high_d   = act_high_q;
    enter_high   = 1'b0;

    case (state_q)
      IDLE: begin
        clk_out_d    = 1'b0;
        running_d    = 1'b0;
        act_period_d = sel_eff_period;
        act_high_d   = sel_eff_high;
        if (enable) begin
          state_d = DELAY;
          cnt_d   = sel_phase;
        end
      end
      DELAY: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          enter_high = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          clk_out_d = 1'b0;
          cnt_d     = low_cnt;
          state_d   = enable ? LOW : STOP_LOW;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      LOW, STOP_LOW: begin
        if (cnt_q == '0) begin
          if (enable) begin
            enter_high = 1'b1;
          end else begin
            state_d   = IDLE;
            running_d = 1'b0;
          end
        end else begin
          cnt_d   = cnt_q - ONE;
          state_d = enable ? LOW : STOP_LOW;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_out_d = 1'b0;
        running_d = 1'b0;
      end
    endcase

    if (enter_high) begin
      state_d      = HIGH;
      cnt_d        = sel_eff_high - ONE;
      clk_out_d    = 1'b1;
      running_d    = 1'b1;
      act_period_d = sel_eff_period;
      act_high_d   = sel_eff_high;
    end
  end

  assign clk_out = clk_out_q;
  assign running = running_q;

`ifdef MULTI_CLOCK_GEN_TICK_EN
  assign rise_tick = clk_out_d & ~clk_out_q;
  assign fall_tick = ~clk_out_d & clk_out_q;
`else
  // Without tick outputs the next-state level only feeds the clk_out register.
`endif

endmodule

// File: rtl/multi_clock_gen.sv
// Multi-channel programmable clock generator. The top level only slices the
// packed config buses and replicates clock_gen_ch once per channel.
// Optional MULTI_CLOCK_GEN_TICK_EN adds per-channel rise_tick/fall_tick.
module multi_clock_gen
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic [NUM_CH*CNT_W-1:0] cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_high,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       running
`ifdef MULTI_CLOCK_GEN_TICK_EN
  ,
  output logic [NUM_CH-1:0]       rise_tick,
  output logic [NUM_CH-1:0]       fall_tick
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_gen_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable[i]),
      .cfg_load  (cfg_load[i]),
      .cfg_period(cfg_period[i*CNT_W +: CNT_W]),
      .cfg_high  (cfg_high[i*CNT_W +: CNT_W]),
      .cfg_phase (cfg_phase[i*CNT_W +: CNT_W]),
      .clk_out   (clk_out[i]),
      .running   (running[i])
`ifdef MULTI_CLOCK_GEN_TICK_EN
      ,
      .rise_tick (rise_tick[i]),
      .fall_tick (fall_tick[i])
`endif
    );
  end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Directed bench for multi_clock_gen. Waveforms are written as strings of
// expected clk_out levels, one character per clk cycle, sampled 1 time unit
// after each rising edge. Tick outputs are checked when
// MULTI_CLOCK_GEN_TICK_EN is defined.
module tb_multi_clock_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       cfg_load;
  logic [NUM_CH*CNT_W-1:0] cfg_period;
  logic [NUM_CH*CNT_W-1:0] cfg_high;
  logic [NUM_CH*CNT_W-1:0] cfg_phase;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       running;
`ifdef MULTI_CLOCK_GEN_TICK_EN
  logic [NUM_CH-1:0]       rise_tick;
  logic [NUM_CH-1:0]       fall_tick;
`endif

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multi_clock_gen #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_load  (cfg_load),
    .cfg_period(cfg_period),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .clk_out   (clk_out),
    .running   (running)
`ifdef MULTI_CLOCK_GEN_TICK_EN
    ,
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input int ch, input int p, input int h, input int ph);
    cfg_period[ch*CNT_W +: CNT_W] = CNT_W'(p);
    cfg_high[ch*CNT_W +: CNT_W]   = CNT_W'(h);
    cfg_phase[ch*CNT_W +: CNT_W]  = CNT_W'(ph);
    cfg_load     = '0;
    cfg_load[ch] = 1'b1;
    step();
    cfg_load = '0;
  endtask

  // One clk cycle per character; the masked channels must all show that level.
  task automatic run_expect(input logic [NUM_CH-1:0] mask, input string tag, input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      logic [NUM_CH-1:0] want;
      step();
      want = (pat[i] == "1") ? mask : '0;
      check($sformatf("%s[%0d].clk_out", tag, i), 32'(clk_out & mask), 32'(want));
`ifdef MULTI_CLOCK_GEN_TICK_EN
      if (i + 1 < pat.len()) begin
        logic [NUM_CH-1:0] want_r, want_f;
        want_r = (pat[i] == "0" && pat[i+1] == "1") ? mask : '0;
        want_f = (pat[i] == "1" && pat[i+1] == "0") ? mask : '0;
        check($sformatf("%s[%0d].rise_tick", tag, i), 32'(rise_tick & mask), 32'(want_r));
        check($sformatf("%s[%0d].fall_tick", tag, i), 32'(fall_tick & mask), 32'(want_f));
      end
`endif
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = '0;
    cfg_load   = '0;
    cfg_period = '0;
    cfg_high   = '0;
    cfg_phase  = '0;

    // Reset state
    #12;
    check("reset.clk_out", 32'(clk_out), 32'h0);
    check("reset.running", 32'(running), 32'h0);
    rst_n = 1'b1;

    // Ch0 period 10, high 5, phase 0
    load_cfg(0, 10, 5, 0);
    enable[0] = 1'b1;
    run_expect(4'b0001, "ch0_start", "0");
    check("ch0.running_pre", 32'(running[0]), 32'h0);
    run_expect(4'b0001, "ch0_rise", "1");
    check("ch0.running_rise", 32'(running[0]), 32'h1);
    run_expect(4'b0001, "ch0_run", "11110000011111000001");
    check("ch0.others_idle", 32'(clk_out[3:1]), 32'h0);

    // enable falls 2 cycles into high: finish high and full low, then IDLE
    run_expect(4'b0001, "ch0_h2", "1");
    enable[0] = 1'b0;
    run_expect(4'b0001, "ch0_stop", "11100000");
    check("ch0.running_stop_low", 32'(running[0]), 32'h1);
    run_expect(4'b0001, "ch0_idle", "0");
    check("ch0.running_idle", 32'(running[0]), 32'h0);

    // enable re-rises during the pending-stop low: resume at period boundary
    enable[0] = 1'b1;
    run_expect(4'b0001, "ch0_re", "011");
    enable[0] = 1'b0;
    run_expect(4'b0001, "ch0_re_drop", "11100");
    enable[0] = 1'b1;
    run_expect(4'b0001, "ch0_re_resume", "0001");
    check("ch0.running_resume", 32'(running[0]), 32'h1);

    // cfg_load period 6 / high 3 mid-period: current period stays 10
    cfg_period[0 +: CNT_W] = 8'd6;
    cfg_high[0 +: CNT_W]   = 8'd3;
    cfg_phase[0 +: CNT_W]  = 8'd0;
    cfg_load[0] = 1'b1;
    run_expect(4'b0001, "ch0_load", "1");
    cfg_load[0] = 1'b0;
    run_expect(4'b0001, "ch0_newcfg", "11100000111000111000");
    enable[0] = 1'b0;
    run_expect(4'b0001, "ch0_off", "0");
    check("ch0.running_off", 32'(running[0]), 32'h0);

    // Ch1 period 8, high 2, phase 3
    load_cfg(1, 8, 2, 3);
    enable[1] = 1'b1;
    run_expect(4'b0010, "ch1_delay", "0000");
    check("ch1.running_delay", 32'(running[1]), 32'h0);
    run_expect(4'b0010, "ch1_run", "1100000011000000");
    check("ch1.running_run", 32'(running[1]), 32'h1);
    enable[1] = 1'b0;
    run_expect(4'b0010, "ch1_off", "0");

    // enable dropped during DELAY: abort, no pulse
    enable[1] = 1'b1;
    run_expect(4'b0010, "ch1_abort_a", "00");
    enable[1] = 1'b0;
    run_expect(4'b0010, "ch1_abort_b", "00000");
    check("ch1.running_abort", 32'(running[1]), 32'h0);

    // Clamp period=1/high=0 on ch2 and ch3, enabled together: edge-aligned
    load_cfg(2, 1, 0, 0);
    load_cfg(3, 1, 0, 0);
    enable[3:2] = 2'b11;
    run_expect(4'b1100, "ch23_clamp", "0101010");
    enable[3:2] = 2'b00;
    run_expect(4'b1100, "ch23_off", "0");

    // Clamp period=4/high=9: high 3, low 1
    load_cfg(3, 4, 9, 0);
    enable[3] = 1'b1;
    run_expect(4'b1000, "ch3_clamp", "011101110");
    enable[3] = 1'b0;
    run_expect(4'b1000, "ch3_off", "0");
    check("ch3.running_off", 32'(running[3]), 32'h0);

    // Reset mid-high truncates at once and restores default config
    enable[0] = 1'b1;
    run_expect(4'b0001, "ch0_prerst", "01");
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid.clk_out", 32'(clk_out), 32'h0);
    check("rst_mid.running", 32'(running), 32'h0);
    #1 rst_n = 1'b1;
    run_expect(4'b0001, "ch0_default", "01010");
    enable[0] = 1'b0;
    run_expect(4'b0001, "ch0_end", "0");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
